// File: rtl/pe_xi_4_pkg.sv
// Shared definitions for the integer motion-estimation SAD processing element:
// pixel width and the encodings of the abs-operand and reference-source controls.
package pe_xi_4_pkg;

    localparam int PIXEL_W = 8;

    typedef enum logic [1:0] {
        ABS_REF  = 2'b00,
        ABS_ADJ1 = 2'b01,
        ABS_ADJ8 = 2'b10,
        ABS_ZERO = 2'b11
    } abs_ctrl_e;

    typedef enum logic {
        REF_ADJ1 = 1'b0,
        REF_ADJ8 = 1'b1
    } ref_src_e;

endpackage

// File: rtl/pe_xi_4_if.sv
// Pixel/control bundle of one SAD processing element. The array controller
// drives through the master modport; the PE itself uses the slave modport.
interface pe_xi_4_if #(
    parameter int PIXEL = pe_xi_4_pkg::PIXEL_W
);
    logic [PIXEL-1:0] in_curr1;
    logic [PIXEL-1:0] in_curr2;
    logic             in_curr_enable;
    logic             CB_select;
    logic [1:0]       abs_Control;
    logic [PIXEL-1:0] down_ref_adajecent_1;
    logic [PIXEL-1:0] down_ref_adajecent_8;
    logic             change_ref;
    logic             ref_input_Control;
    logic [PIXEL-1:0] abs_out;
    logic [PIXEL-1:0] next_pix1;
    logic [PIXEL-1:0] next_pix2;
    logic [PIXEL-1:0] ref_pix;

    modport master (
        output in_curr1, in_curr2, in_curr_enable, CB_select, abs_Control,
               down_ref_adajecent_1, down_ref_adajecent_8, change_ref,
               ref_input_Control,
        input  abs_out, next_pix1, next_pix2, ref_pix
    );

    modport slave (
        input  in_curr1, in_curr2, in_curr_enable, CB_select, abs_Control,
               down_ref_adajecent_1, down_ref_adajecent_8, change_ref,
               ref_input_Control,
        output abs_out, next_pix1, next_pix2, ref_pix
    );
endinterface

// File: rtl/pe_xi_4_abs_diff.sv
// Combinational unsigned |a - b|, shared by every PE of the SAD array.
// The difference is formed one bit wider and signed so its magnitude never overflows.
module pe_xi_4_abs_diff #(
    parameter int PIXEL = pe_xi_4_pkg::PIXEL_W
) (
    input  logic [PIXEL-1:0] a_i,
    input  logic [PIXEL-1:0] b_i,
    output logic [PIXEL-1:0] diff_o
);

    function automatic logic [PIXEL-1:0] magnitude(input logic signed [PIXEL:0] d);
        logic signed [PIXEL:0] m;
        m = d[PIXEL] ? -d : d;
        return m[PIXEL-1:0];
    endfunction

    logic signed [PIXEL:0] diff_s;

    always_comb begin
        diff_s = $signed({1'b0, a_i}) - $signed({1'b0, b_i});
        diff_o = magnitude(diff_s);
    end

endmodule

// File: rtl/pe_xi_4.sv
// One SAD processing element: holds two current-block pixels and one reference
// pixel, forwards them along the array, and registers |cur - operand|.
module pe_xi_4
    import pe_xi_4_pkg::*;
#(
    parameter int PIXEL = PIXEL_W
) (
    input  logic     clk,
    input  logic     rst_n,
    pe_xi_4_if.slave pe
);

    logic [PIXEL-1:0] curr1_q, curr1_d;
    logic [PIXEL-1:0] curr2_q, curr2_d;
    logic [PIXEL-1:0] ref_q,   ref_d;
    logic [PIXEL-1:0] abs_q,   abs_d;

    logic [PIXEL-1:0] cur_sel;
    logic [PIXEL-1:0] abs_opnd;
    logic [PIXEL-1:0] abs_mag;
    abs_ctrl_e        abs_mode;

    always_comb begin
        curr1_d = curr1_q;
        curr2_d = curr2_q;
        if (pe.in_curr_enable) begin
            curr1_d = pe.in_curr1;
            curr2_d = pe.in_curr2;
        end
    end

    always_comb begin
        ref_d = ref_q;
        if (pe.change_ref) begin
            ref_d = (ref_src_e'(pe.ref_input_Control) == REF_ADJ8) ?
                    pe.down_ref_adajecent_8 : pe.down_ref_adajecent_1;
        end
    end

    // The difference path sees only pre-edge register contents, so a load on
    // the same edge shows up in abs_out one cycle later.
    always_comb begin
        abs_mode = abs_ctrl_e'(pe.abs_Control);
        cur_sel  = pe.CB_select ? curr2_q : curr1_q;
        case (abs_mode)
            ABS_ADJ1: abs_opnd = pe.down_ref_adajecent_1;
            ABS_ADJ8: abs_opnd = pe.down_ref_adajecent_8;
            default:  abs_opnd = ref_q;
        endcase
        abs_d = (abs_mode == ABS_ZERO) ? '0 : abs_mag;
    end

    pe_xi_4_abs_diff #(
        .PIXEL (PIXEL)
    ) u_abs_diff (
        .a_i    (cur_sel),
        .b_i    (abs_opnd),
        .diff_o (abs_mag)
    );

    // Register stage: pixel storage and absolute-difference output
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            curr1_q <= '0;
            curr2_q <= '0;
            ref_q   <= '0;
            abs_q   <= '0;
        end else begin
            curr1_q <= curr1_d;
            curr2_q <= curr2_d;
            ref_q   <= ref_d;
            abs_q   <= abs_d;
        end
    end

    assign pe.abs_out   = abs_q;
    assign pe.next_pix1 = curr1_q;
    assign pe.next_pix2 = curr2_q;
    assign pe.ref_pix   = ref_q;

endmodule

// File: tb/tb_pe_xi_4.sv
// Bench for the SAD processing element: directed vector table, async-reset
// sequences and a randomized run against a behavioural pixel model.
module tb_pe_xi_4;

    logic clk = 1'b0;
    logic rst_n;

    pe_xi_4_if bus ();

    pe_xi_4 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pe    (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] m_c1 = 8'h00;
    logic [7:0] m_c2 = 8'h00;
    logic [7:0] m_r  = 8'h00;
    logic [7:0] m_a  = 8'h00;

    typedef struct packed {
        logic [7:0] c1;
        logic [7:0] c2;
        logic       en;
        logic       cb;
        logic [1:0] ac;
        logic [7:0] a1;
        logic [7:0] a8;
        logic       chg;
        logic       rsel;
        logic [7:0] e_n1;
        logic [7:0] e_n2;
        logic [7:0] e_ref;
        logic [7:0] e_abs;
    } vec_t;

    vec_t vecs [13];

    function automatic logic [7:0] absdiff(input int a, input int b);
        int d;
        d = (a > b) ? (a - b) : (b - a);
        return 8'(d);
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h, expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".next_pix1"}, bus.next_pix1, m_c1);
        chk({tag, ".next_pix2"}, bus.next_pix2, m_c2);
        chk({tag, ".ref_pix"},   bus.ref_pix,   m_r);
        chk({tag, ".abs_out"},   bus.abs_out,   m_a);
    endtask

    // Model of one clock edge, computed from the pixel rules with plain arithmetic.
    task automatic tick();
        logic [7:0] n_c1, n_c2, n_r, n_a;
        int cur;
        cur  = bus.CB_select ? int'(m_c2) : int'(m_c1);
        n_c1 = bus.in_curr_enable ? bus.in_curr1 : m_c1;
        n_c2 = bus.in_curr_enable ? bus.in_curr2 : m_c2;
        n_r  = !bus.change_ref ? m_r :
               (bus.ref_input_Control ? bus.down_ref_adajecent_8 : bus.down_ref_adajecent_1);
        case (bus.abs_Control)
            2'd0:    n_a = absdiff(cur, int'(m_r));
            2'd1:    n_a = absdiff(cur, int'(bus.down_ref_adajecent_1));
            2'd2:    n_a = absdiff(cur, int'(bus.down_ref_adajecent_8));
            default: n_a = 8'h00;
        endcase
        if (rst_n) begin
            n_c1 = 8'h00; n_c2 = 8'h00; n_r = 8'h00; n_a = 8'h00;
        end
        @(posedge clk);
        m_c1 = n_c1; m_c2 = n_c2; m_r = n_r; m_a = n_a;
        #1;
    endtask

    task automatic randomize_inputs();
        bus.in_curr1             = 8'($urandom);
        bus.in_curr2             = 8'($urandom);
        bus.in_curr_enable       = 1'($urandom);
        bus.CB_select            = 1'($urandom);
        bus.abs_Control          = 2'($urandom);
        bus.down_ref_adajecent_1 = 8'($urandom);
        bus.down_ref_adajecent_8 = 8'($urandom);
        bus.change_ref           = 1'($urandom);
        bus.ref_input_Control    = 1'($urandom);
    endtask

    task automatic apply(input vec_t v);
        bus.in_curr1             = v.c1;
        bus.in_curr2             = v.c2;
        bus.in_curr_enable       = v.en;
        bus.CB_select            = v.cb;
        bus.abs_Control          = v.ac;
        bus.down_ref_adajecent_1 = v.a1;
        bus.down_ref_adajecent_8 = v.a8;
        bus.change_ref           = v.chg;
        bus.ref_input_Control    = v.rsel;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset_pulse(input string tag);
        #2 rst_n = 1'b1;
        #1;
        m_c1 = 8'h00; m_c2 = 8'h00; m_r = 8'h00; m_a = 8'h00;
        check_all(tag);
        #1 rst_n = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //           c1     c2     en    cb    ac     a1     a8     chg   rsel  n1     n2     ref    abs
        vecs[0]  = '{8'h0F, 8'h07, 1'b1, 1'b1, 2'b11, 8'h01, 8'h02, 1'b1, 1'b0, 8'h0F, 8'h07, 8'h01, 8'h00};
        vecs[1]  = '{8'hAA, 8'hBB, 1'b0, 1'b1, 2'b11, 8'h05, 8'h02, 1'b1, 1'b1, 8'h0F, 8'h07, 8'h02, 8'h00};
        vecs[2]  = '{8'hCC, 8'hDD, 1'b0, 1'b1, 2'b11, 8'h33, 8'h44, 1'b0, 1'b0, 8'h0F, 8'h07, 8'h02, 8'h00};
        vecs[3]  = '{8'h00, 8'h00, 1'b0, 1'b1, 2'b00, 8'h01, 8'h02, 1'b1, 1'b0, 8'h0F, 8'h07, 8'h01, 8'h05};
        vecs[4]  = '{8'h00, 8'h00, 1'b0, 1'b1, 2'b00, 8'h01, 8'h02, 1'b0, 1'b0, 8'h0F, 8'h07, 8'h01, 8'h06};
        vecs[5]  = '{8'h00, 8'h00, 1'b0, 1'b0, 2'b00, 8'h01, 8'h02, 1'b0, 1'b0, 8'h0F, 8'h07, 8'h01, 8'h0E};
        vecs[6]  = '{8'h00, 8'h00, 1'b0, 1'b1, 2'b01, 8'h01, 8'h02, 1'b0, 1'b0, 8'h0F, 8'h07, 8'h01, 8'h06};
        vecs[7]  = '{8'h00, 8'h00, 1'b0, 1'b1, 2'b10, 8'h01, 8'h02, 1'b0, 1'b0, 8'h0F, 8'h07, 8'h01, 8'h05};
        vecs[8]  = '{8'h00, 8'h00, 1'b0, 1'b1, 2'b11, 8'h01, 8'h02, 1'b0, 1'b0, 8'h0F, 8'h07, 8'h01, 8'h00};
        vecs[9]  = '{8'h01, 8'h01, 1'b1, 1'b0, 2'b11, 8'h01, 8'h02, 1'b0, 1'b0, 8'h01, 8'h01, 8'h01, 8'h00};
        vecs[10] = '{8'h00, 8'h00, 1'b0, 1'b0, 2'b01, 8'hFF, 8'h02, 1'b0, 1'b0, 8'h01, 8'h01, 8'h01, 8'hFE};
        // Same-edge hazard: new pixels and ref load while mode 00 samples the old ones
        vecs[11] = '{8'h20, 8'h30, 1'b1, 1'b0, 2'b00, 8'hFF, 8'h10, 1'b1, 1'b1, 8'h20, 8'h30, 8'h10, 8'h00};
        vecs[12] = '{8'h00, 8'h00, 1'b0, 1'b1, 2'b00, 8'hFF, 8'h10, 1'b0, 1'b0, 8'h20, 8'h30, 8'h10, 8'h20};

        // Reset held over two edges with random inputs
        rst_n = 1'b1;
        randomize_inputs();
        for (int i = 0; i < 2; i++) begin
            tick();
            check_all($sformatf("reset_hold%0d", i));
            randomize_inputs();
        end
        #2 rst_n = 1'b0;

        for (int i = 0; i < 13; i++) begin
            apply(vecs[i]);
            tick();
            chk($sformatf("vec%0d.next_pix1", i), bus.next_pix1, vecs[i].e_n1);
            chk($sformatf("vec%0d.next_pix2", i), bus.next_pix2, vecs[i].e_n2);
            chk($sformatf("vec%0d.ref_pix", i),   bus.ref_pix,   vecs[i].e_ref);
            chk($sformatf("vec%0d.abs_out", i),   bus.abs_out,   vecs[i].e_abs);
        end

        // Async reset mid-operation: outputs clear before any clock edge
        bus.in_curr_enable = 1'b1;
        bus.change_ref     = 1'b1;
        bus.abs_Control    = 2'b01;
        async_reset_pulse("async_mid");
        tick();
        check_all("after_async_edge");

        // Reset held across an edge with loads enabled, then released away from the edge
        #2 rst_n = 1'b1;
        randomize_inputs();
        bus.in_curr_enable = 1'b1;
        bus.change_ref     = 1'b1;
        tick();
        check_all("reset_over_load");
        #2 rst_n = 1'b0;
        bus.in_curr_enable = 1'b0;
        bus.change_ref     = 1'b0;
        bus.abs_Control    = 2'b00;
        tick();
        check_all("post_reset_hold");

        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            if ($urandom_range(0, 39) == 0) async_reset_pulse($sformatf("rand_async%0d", i));
            tick();
            check_all($sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
